// File: rtl/level_reorder_buffer.sv
// rtl/level_reorder_buffer.sv - two-bank store that replays CAVLC levels in forward scan order
// Optional feature: define LEVEL_REORDER_ZERO_PAD_EN to pad every block to DEPTH coefficients.
module level_reorder_buffer #(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = 13
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic [LEVEL_W-1:0]       LevelIn,
  input  logic                     WrReq,
  input  logic                     BlockDone,
  output logic                     Stall,
  output logic [LEVEL_W-1:0]       CoeffOut,
  output logic [$clog2(DEPTH)-1:0] CoeffIndex,
  output logic                     CoeffValid,
  input  logic                     CoeffReady,
  output logic                     CoeffLast,
  output logic                     Overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] One     = CNT_W'(1);
`ifdef LEVEL_REORDER_ZERO_PAD_EN
  localparam logic [CNT_W-1:0] IdxMax  = CNT_W'(DEPTH - 1);
`endif

  typedef enum logic {
    Idle = 1'b0,
    Emit = 1'b1
  } rdState_t;

  logic [LEVEL_W-1:0] bankMem [2][DEPTH];
  logic [CNT_W-1:0]   bankCount [2];
  logic [1:0]         bankFull;
  logic               wrBank;
  logic               rdBank;
  logic [CNT_W-1:0]   wrCount;
  logic               overflowReg;

  rdState_t           state;
  rdState_t           stateNext;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   idxNext;

  logic               wrAccept;
  logic               closeAccept;
  logic               dropErr;
  logic [CNT_W-1:0]   closeCount;

  logic [CNT_W-1:0]   curCount;
  logic               emitting;
  logic               inRange;
  logic               lastPos;
  logic               emptyBank;
  logic               fire;
  logic               rdRelease;
  logic [IDX_W-1:0]   rdAddr;

  // Write side: the bank under wrBank fills until BlockDone closes it.
  assign Stall       = bankFull[wrBank];
  assign wrAccept    = WrReq && !Stall && (wrCount != CntFull);
  assign closeAccept = BlockDone && !Stall;
  assign closeCount  = wrAccept ? (wrCount + One) : wrCount;
  assign dropErr     = (WrReq && !wrAccept) || (BlockDone && Stall);

  always_ff @(posedge Clk) begin
    if (wrAccept) begin
      bankMem[wrBank][wrCount[IDX_W-1:0]] <= LevelIn;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      bankFull     <= '0;
      bankCount[0] <= '0;
      bankCount[1] <= '0;
      wrBank       <= 1'b0;
      rdBank       <= 1'b0;
      wrCount      <= '0;
      overflowReg  <= 1'b0;
    end else begin
      if (wrAccept) begin
        wrCount <= wrCount + One;
      end
      if (closeAccept) begin
        bankFull[wrBank]  <= 1'b1;
        bankCount[wrBank] <= closeCount;
        wrBank            <= ~wrBank;
        wrCount           <= '0;
      end
      // A releasing bank is always the read bank, never the one being closed.
      if (rdRelease) begin
        bankFull[rdBank] <= 1'b0;
        rdBank           <= ~rdBank;
      end
      if (dropErr) begin
        overflowReg <= 1'b1;
      end
    end
  end

  assign Overflow = overflowReg;

  // Read side: levels arrive highest frequency first, so scan position idx maps to count-1-idx.
  assign curCount = bankCount[rdBank];
  assign emitting = (state == Emit);
  assign inRange  = (idx < curCount);
  assign rdAddr   = IDX_W'(curCount - idx - One);

`ifdef LEVEL_REORDER_ZERO_PAD_EN
  assign lastPos   = (idx == IdxMax);
  assign emptyBank = 1'b0;
`else
  assign lastPos   = (idx == (curCount - One));
  assign emptyBank = (curCount == '0);
`endif

  assign CoeffValid = emitting && !emptyBank;
  assign fire       = CoeffValid && CoeffReady;
  assign CoeffOut   = (emitting && inRange) ? bankMem[rdBank][rdAddr] : '0;
  assign CoeffIndex = emitting ? idx[IDX_W-1:0] : '0;
  assign CoeffLast  = CoeffValid && lastPos;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= Idle;
      idx   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    rdRelease = 1'b0;
    case (state)
      Idle: begin
        if (bankFull[rdBank]) begin
          stateNext = Emit;
          idxNext   = '0;
        end
      end
      Emit: begin
        if (emptyBank || (fire && lastPos)) begin
          rdRelease = 1'b1;
          idxNext   = '0;
          // Chain straight into the other bank when it is already waiting.
          stateNext = bankFull[~rdBank] ? Emit : Idle;
        end else if (fire) begin
          idxNext = idx + One;
        end
      end
      default: begin
        stateNext = Idle;
      end
    endcase
  end

endmodule

// File: tb/tb_level_reorder_buffer.sv
// tb/tb_level_reorder_buffer.sv - scoreboard bench for level_reorder_buffer
// Reference model reverses each closed block from a queue and tracks bank occupancy.
module tb_level_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int LW    = 13;

  logic          Clk = 1'b0;
  logic          nReset = 1'b1;
  logic [LW-1:0] LevelIn = '0;
  logic          WrReq = 1'b0;
  logic          BlockDone = 1'b0;
  logic          CoeffReady = 1'b0;
  logic          Stall;
  logic [LW-1:0] CoeffOut;
  logic [3:0]    CoeffIndex;
  logic          CoeffValid;
  logic          CoeffLast;
  logic          Overflow;

  level_reorder_buffer #(.DEPTH(DEPTH), .LEVEL_W(LW)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .LevelIn   (LevelIn),
    .WrReq     (WrReq),
    .BlockDone (BlockDone),
    .Stall     (Stall),
    .CoeffOut  (CoeffOut),
    .CoeffIndex(CoeffIndex),
    .CoeffValid(CoeffValid),
    .CoeffReady(CoeffReady),
    .CoeffLast (CoeffLast),
    .Overflow  (Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [LW-1:0] val;
    int            pos;
    bit            last;
  } coeff_t;

  coeff_t        expQ[$];
  logic [LW-1:0] cur[$];
  int            occ = 0;
  int            wrCnt = 0;
  int            emptyCd = 0;
  int            relSeen = 0;
  int            relDone = 0;
  int            readyMode = 0;
  bit            expOvf = 0;
  bit            stalled = 0;
  bit            holdArmed = 0;
  bit            gapCheck = 0;
  logic [LW-1:0] heldOut;
  logic [3:0]    heldIdx;
  logic          heldLast;
  int            compared = 0;
  int            mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string what);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout expected completion at %0t", what, $time);
  endtask

  task automatic closeBlock();
    int n = cur.size();
    coeff_t e;
`ifdef LEVEL_REORDER_ZERO_PAD_EN
    for (int i = 0; i < DEPTH; i++) begin
      e.val  = (i < n) ? cur[n-1-i] : '0;
      e.pos  = i;
      e.last = (i == DEPTH - 1);
      expQ.push_back(e);
    end
`else
    for (int i = 0; i < n; i++) begin
      e.val  = cur[n-1-i];
      e.pos  = i;
      e.last = (i == n - 1);
      expQ.push_back(e);
    end
    if (n == 0) emptyCd = 2;
`endif
    cur.delete();
    wrCnt = 0;
    occ++;
  endtask

  // Model: what the decoder handed over at each edge, and which banks are occupied.
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cur.delete();
      expQ.delete();
      occ = 0;
      wrCnt = 0;
      emptyCd = 0;
      expOvf = 0;
      relDone = relSeen;
    end else begin
      stalled = (occ == 2);
      if (emptyCd != 0) begin
        emptyCd--;
        if (emptyCd == 0) occ--;
      end
      if (WrReq) begin
        if (stalled || wrCnt == DEPTH) expOvf = 1;
        else begin
          cur.push_back(LevelIn);
          wrCnt++;
        end
      end
      if (BlockDone) begin
        if (stalled) expOvf = 1;
        else closeBlock();
      end
      if (relSeen != relDone) begin
        relDone = relSeen;
        occ--;
      end
    end
  end

  always @(posedge Clk) begin
    #1;
    case (readyMode)
      0:       CoeffReady = 1'b0;
      1:       CoeffReady = 1'b1;
      2:       CoeffReady = 1'($urandom_range(0, 1));
      default: CoeffReady = ~CoeffReady;
    endcase
  end

  // Monitor: compares every presented coefficient against the scoreboard head.
  always @(negedge Clk) begin
    if (!nReset) begin
      holdArmed = 0;
      gapCheck  = 0;
    end else begin
      chk("stall", Stall, occ == 2);
      chk("overflow", Overflow, expOvf);
      if (gapCheck) begin
        chk("no_bubble", CoeffValid, 1);
        gapCheck = 0;
      end
      if (CoeffValid) begin
        if (holdArmed) begin
          chk("hold_out", CoeffOut, heldOut);
          chk("hold_index", CoeffIndex, heldIdx);
          chk("hold_last", CoeffLast, heldLast);
        end
        holdArmed = 0;
        if (expQ.size() == 0) begin
          chk("unexpected_valid", CoeffValid, 0);
        end else begin
          chk("coeff_out", CoeffOut, expQ[0].val);
          chk("coeff_index", CoeffIndex, expQ[0].pos);
          chk("coeff_last", CoeffLast, expQ[0].last);
          if (CoeffReady) begin
            if (expQ[0].last) begin
              relSeen++;
              gapCheck = (expQ.size() > 1);
            end
            void'(expQ.pop_front());
          end else begin
            holdArmed = 1;
            heldOut   = CoeffOut;
            heldIdx   = CoeffIndex;
            heldLast  = CoeffLast;
          end
        end
      end else begin
        if (holdArmed) chk("valid_held", CoeffValid, 1);
        holdArmed = 0;
      end
    end
  end

  task automatic step(input logic wr, input logic [LW-1:0] v, input logic done);
    WrReq     = wr;
    LevelIn   = v;
    BlockDone = done;
    @(posedge Clk);
    #1;
    WrReq     = 1'b0;
    BlockDone = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic waitFree();
    int g = 0;
    while (occ == 2 && g < 3000) begin
      idle(1);
      g++;
    end
    if (g >= 3000) timeout("wait_free");
  endtask

  task automatic sendLevels(input int n, input bit sameCycle);
    for (int i = 0; i < n; i++) begin
      waitFree();
      step(1'b1, LW'($urandom), sameCycle && (i == n - 1));
    end
    if (!sameCycle || n == 0) begin
      waitFree();
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((occ != 0 || expQ.size() != 0 || emptyCd != 0) && g < 3000) begin
      idle(1);
      g++;
    end
    if (g >= 3000) timeout("drain");
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_stall"}, Stall, 0);
    chk({tag, "_valid"}, CoeffValid, 0);
    chk({tag, "_out"}, CoeffOut, 0);
    chk({tag, "_index"}, CoeffIndex, 0);
    chk({tag, "_last"}, CoeffLast, 0);
    chk({tag, "_overflow"}, Overflow, 0);
  endtask

  task automatic releaseReset();
    @(negedge Clk);
    @(negedge Clk);
    nReset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1 nReset = 1'b0;
    repeat (2) @(negedge Clk);
    checkResetOutputs("reset");
    releaseReset();

    // Reverse and pad, plus first-coefficient latency.
    readyMode = 1;
    idle(1);
    step(1'b1, LW'(5), 1'b0);
    step(1'b1, LW'(-3), 1'b0);
    step(1'b1, LW'(1), 1'b0);
    step(1'b0, '0, 1'b1);
    @(negedge Clk);
    chk("latency_idle", CoeffValid, 0);
    @(negedge Clk);
    chk("latency_first", CoeffValid, 1);
    chk("first_coeff", CoeffOut, 1);
    drain();

    // Back-pressure on a full block.
    readyMode = 3;
    sendLevels(DEPTH, 1'b0);
    drain();

    // Same-cycle write and close.
    readyMode = 1;
    idle(1);
    step(1'b1, LW'(7), 1'b1);
    drain();

    // Empty block, then a normal block through the freed bank.
    step(1'b0, '0, 1'b1);
    idle(4);
    drain();
    sendLevels(2, 1'b0);
    drain();

    // Both banks fill while the consumer is stalled.
    readyMode = 0;
    idle(2);
    sendLevels(4, 1'b0);
    sendLevels(3, 1'b0);
    idle(1);
    step(1'b1, LW'(9), 1'b0);
    step(1'b0, '0, 1'b1);
    idle(4);
    readyMode = 1;
    drain();

    // Reset in the middle of an emitted block.
    sendLevels(10, 1'b0);
    begin
      int g = 0;
      do begin
        @(negedge Clk);
        #2;
        g++;
      end while (!(CoeffValid && CoeffIndex == 4'd6) && g < 200);
      if (g >= 200) timeout("reach_index6");
    end
    nReset = 1'b0;
    #1;
    checkResetOutputs("midreset");
    releaseReset();
    sendLevels(3, 1'b0);
    drain();

    // More writes than a bank can hold.
    sendLevels(DEPTH + 1, 1'b0);
    drain();

    nReset = 1'b0;
    releaseReset();

    // Randomized blocks with random consumer back-pressure.
    readyMode = 2;
    for (int b = 0; b < 40; b++) begin
`ifdef LEVEL_REORDER_ZERO_PAD_EN
      sendLevels($urandom_range(0, DEPTH), 1'($urandom_range(0, 1)));
`else
      sendLevels($urandom_range(1, DEPTH), 1'($urandom_range(0, 1)));
`endif
      idle($urandom_range(0, 3));
    end
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

endmodule
